// File: rtl/cart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cart_pkg
// Purpose  : Shared cartridge-scan types and sizing constants.
// Revision : 1.0 - initial release
// ============================================================================
package cart_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int MAX_ROM_BYTES = 1 << ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_t;

endpackage : cart_pkg
`default_nettype wire

// File: rtl/rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rd_pipe
// Purpose  : LATENCY-deep valid/address delay line matching a BRAM read port.
// Revision : 1.0 - initial release
// ============================================================================
module rd_pipe #(
    parameter int LATENCY = 1,
    parameter int AW      = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    input  logic [AW-1:0] i_addr,
    output logic          o_vld,
    output logic [AW-1:0] o_addr,
    output logic          o_any
);

    logic [LATENCY-1:0] r_vld;
    logic [AW-1:0]      r_addr [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            r_addr[0] <= i_addr;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    assign o_vld  = r_vld[LATENCY-1];
    assign o_addr = r_addr[LATENCY-1];
    // Any read still in flight, including the one about to emerge
    assign o_any  = |r_vld;

endmodule : rd_pipe
`default_nettype wire

// File: rtl/rom_scan.sv
`default_nettype none
// ============================================================================
// Module   : rom_scan
// Purpose  : Walks a loaded cart image and streams (address, byte) strobes.
// Revision : 1.0 - initial release
// ============================================================================
module rom_scan
    import cart_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       rom_size,
    input  logic              mem_grant,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              det_clear,
    output logic              scan_ena,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [7:0]        scan_data,
    output logic              busy,
    output logic              done
);

    // Size arithmetic is wide enough for both rom_size and 2^ADDR_W
    localparam int SW = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
    localparam logic [SW-1:0] C_MAX = SW'(1) << ADDR_W;

    scan_state_t     r_state;
    logic            r_start_q;
    logic [ADDR_W:0] r_cnt;
    logic [SW-1:0]   r_n;

    logic              w_start_acc;
    logic              w_last;
    logic [SW-1:0]     w_rs;
    logic [SW-1:0]     w_n;
    logic              w_pipe_vld;
    logic              w_pipe_any;
    logic [ADDR_W-1:0] w_pipe_addr;

    assign w_rs        = SW'(rom_size);
    assign w_n         = (w_rs > C_MAX) ? C_MAX : w_rs;
    assign w_start_acc = start & ~r_start_q &
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last      = ((SW'(r_cnt) + SW'(1)) == r_n);

    assign mem_rd   = (r_state == ST_SCAN) & mem_grant;
    assign mem_addr = r_cnt[ADDR_W-1:0];

    rd_pipe #(
        .LATENCY (READ_LATENCY),
        .AW      (ADDR_W)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (reset),
        .i_vld  (mem_rd),
        .i_addr (mem_addr),
        .o_vld  (w_pipe_vld),
        .o_addr (w_pipe_addr),
        .o_any  (w_pipe_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_cnt     <= '0;
            r_n       <= '0;
            det_clear <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            scan_ena  <= 1'b0;
            scan_addr <= '0;
            scan_data <= '0;
        end else begin
            r_start_q <= start;
            det_clear <= 1'b0;
            scan_ena  <= w_pipe_vld;
            if (w_pipe_vld) begin
                scan_addr <= w_pipe_addr;
                scan_data <= mem_data;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_acc) begin
                        r_state   <= ST_CLEAR;
                        det_clear <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        r_cnt     <= '0;
                        r_n       <= w_n;
                    end
                end
                ST_CLEAR: begin
                    if (r_n != '0) begin
                        r_state <= ST_SCAN;
                    end else begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (mem_grant) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Final strobe is on the outputs and nothing is left in flight
                    if (scan_ena && !w_pipe_any) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : rom_scan
`default_nettype wire

// File: tb/tb_rom_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_scan
// Purpose  : Randomized self-checking bench; latency 1 and latency 3 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_scan;

    localparam int AW  = 15;
    localparam int MAX = 1 << AW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] rom_size = '0;
    logic        mem_grant = 1'b0;

    logic          mem_rd_w    [2];
    logic [AW-1:0] mem_addr_w  [2];
    logic [7:0]    mem_data_w  [2];
    logic          det_clear_w [2];
    logic          scan_ena_w  [2];
    logic [AW-1:0] scan_addr_w [2];
    logic [7:0]    scan_data_w [2];
    logic          busy_w      [2];
    logic          done_w      [2];

    logic [7:0] mem [MAX];
    logic [7:0] p1, p2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int armed      [2];
    int issued     [2];
    int exp_addr   [2];
    int clears     [2];
    int clear_cyc  [2];
    int last_cyc   [2];
    int busy_cyc   [2];
    int total_strb [2];
    int prev_done  [2];
    int rdq0 [$];
    int rdq1 [$];

    always #5 clk = ~clk;

    rom_scan #(.READ_LATENCY(1), .ADDR_W(AW)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .rom_size(rom_size),
        .mem_grant(mem_grant), .mem_rd(mem_rd_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_data(mem_data_w[0]), .det_clear(det_clear_w[0]),
        .scan_ena(scan_ena_w[0]), .scan_addr(scan_addr_w[0]),
        .scan_data(scan_data_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    rom_scan #(.READ_LATENCY(3), .ADDR_W(AW)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .rom_size(rom_size),
        .mem_grant(mem_grant), .mem_rd(mem_rd_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_data(mem_data_w[1]), .det_clear(det_clear_w[1]),
        .scan_ena(scan_ena_w[1]), .scan_addr(scan_addr_w[1]),
        .scan_data(scan_data_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    // BRAM models: one and three cycles of read latency
    always @(posedge clk) begin
        mem_data_w[0] <= mem[mem_addr_w[0]];
        p1            <= mem[mem_addr_w[1]];
        p2            <= p1;
        mem_data_w[1] <= p2;
        cyc           <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: strobes must walk 0..N-1 in order with bytes from mem
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                armed[i] = 0; issued[i] = 0; exp_addr[i] = 0; prev_done[i] = 0;
                if (i == 0) rdq0.delete(); else rdq1.delete();
            end else begin
                if (det_clear_w[i]) begin
                    clears[i]++; armed[i] = 1; issued[i] = 0; exp_addr[i] = 0;
                    clear_cyc[i] = cyc; busy_cyc[i] = 0;
                    if (i == 0) rdq0.delete(); else rdq1.delete();
                end
                if (busy_w[i]) busy_cyc[i]++;
                if (mem_rd_w[i]) begin
                    chk($sformatf("u%0d.rd_addr", i), 32'(mem_addr_w[i]), 32'(issued[i]));
                    issued[i]++;
                    if (i == 0) rdq0.push_back(cyc); else rdq1.push_back(cyc);
                end
                if (scan_ena_w[i]) begin
                    int t;
                    if (i == 0) t = (rdq0.size() > 0) ? rdq0.pop_front() : -100;
                    else        t = (rdq1.size() > 0) ? rdq1.pop_front() : -100;
                    chk($sformatf("u%0d.strobe_armed", i), 32'(armed[i]), 32'd1);
                    chk($sformatf("u%0d.scan_addr", i), 32'(scan_addr_w[i]), 32'(exp_addr[i]));
                    chk($sformatf("u%0d.scan_data", i), 32'(scan_data_w[i]),
                        32'(mem[exp_addr[i] % MAX]));
                    chk($sformatf("u%0d.latency", i), 32'(cyc - t), 32'((i == 0) ? 2 : 4));
                    chk($sformatf("u%0d.busy_strobe", i), 32'(busy_w[i]), 32'd1);
                    exp_addr[i]++; total_strb[i]++; last_cyc[i] = cyc;
                end
                if (done_w[i] && !prev_done[i] && armed[i] != 0) begin
                    chk($sformatf("u%0d.done_time", i), 32'(cyc),
                        32'(((exp_addr[i] > 0) ? last_cyc[i] : clear_cyc[i]) + 1));
                    chk($sformatf("u%0d.busy_len", i), 32'(busy_cyc[i]), 32'(cyc - clear_cyc[i]));
                    chk($sformatf("u%0d.done_busy", i), 32'(busy_w[i]), 32'd0);
                    armed[i] = 0;
                end
                prev_done[i] = int'(done_w[i]);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s.u%0d.outs", tag, i),
                {mem_rd_w[i], det_clear_w[i], scan_ena_w[i], busy_w[i], done_w[i]}, 32'd0);
            chk($sformatf("%s.u%0d.addrs", tag, i),
                {mem_addr_w[i], scan_addr_w[i]}, 32'd0);
            chk($sformatf("%s.u%0d.sdata", tag, i), 32'(scan_data_w[i]), 32'd0);
        end
    endtask

    // mode: 0 grant always, 1 pattern 1,0,0, 2 random
    task automatic do_scan(input int size, input int mode, input bit hold, input bit repulse);
        int n, c0[2], ok;
        n = (size > MAX) ? MAX : size;
        c0[0] = clears[0]; c0[1] = clears[1];
        rom_size = 16'(size);
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.clear_pulse", i), {det_clear_w[i], busy_w[i], done_w[i]}, 32'b110);
            chk($sformatf("u%0d.clear_rd", i), 32'(mem_rd_w[i]), 32'd0);
        end
        rom_size = 16'($urandom);
        if (!hold) start = 1'b0;
        ok = 0;
        for (int c = 0; c < 4 * n + 200; c++) begin
            case (mode)
                0:       mem_grant = 1'b1;
                1:       mem_grant = (c % 3 == 0);
                default: mem_grant = 1'($urandom);
            endcase
            if (repulse && c == 4) start = 1'b0;
            if (repulse && c == 5) start = 1'b1;
            @(posedge clk); #1;
            if (done_w[0] && done_w[1]) begin
                ok = 1;
                break;
            end
        end
        mem_grant = 1'b0;
        chk("done_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.strobes", i), 32'(exp_addr[i]), 32'(n));
            if (n > 0)
                chk($sformatf("u%0d.last_addr", i), 32'(scan_addr_w[i]), 32'(n - 1));
        end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.one_clear", i), 32'(clears[i] - c0[i]), 32'd1);
            chk($sformatf("u%0d.done_hold", i), {busy_w[i], done_w[i]}, 32'b01);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int s0, s1, ok;
        for (int a = 0; a < MAX; a++) mem[a] = 8'($urandom);
        mem[0] = 8'h8D; mem[1] = 8'hE0; mem[2] = 8'h1F; mem[3] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            clears[i] = 0; total_strb[i] = 0; busy_cyc[i] = 0;
            clear_cyc[i] = 0; last_cyc[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;
        @(posedge clk); #1;

        do_scan(4, 0, 1'b0, 1'b0);
        chk("e0_at_addr1", 32'(mem[1]), 32'hE0);
        do_scan(16, 1, 1'b0, 1'b0);
        do_scan(0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) do_scan(int'($urandom_range(1, 64)), 2, 1'b0, 1'b0);
        do_scan(20, 2, 1'b1, 1'b1);
        do_scan(5, 0, 1'b1, 1'b0);

        // Reset in the middle of a scan
        rom_size = 16'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ok = 0;
        for (int c = 0; c < 100; c++) begin
            mem_grant = 1'b1;
            if (mem_rd_w[0] && mem_addr_w[0] == 15'd7) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_addr7", 32'(ok), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        mem_grant = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        s0 = total_strb[0]; s1 = total_strb[1];
        repeat (12) @(posedge clk);
        #1;
        chk("u0.no_strobe_after_rst", 32'(total_strb[0] - s0), 32'd0);
        chk("u1.no_strobe_after_rst", 32'(total_strb[1] - s1), 32'd0);
        chk("idle_after_rst", {busy_w[0], done_w[0], busy_w[1], done_w[1]}, 32'd0);
        do_scan(10, 2, 1'b0, 1'b0);

        do_scan(40000, 0, 1'b0, 1'b0);
        chk("u0.final_addr", 32'(scan_addr_w[0]), 32'h7FFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rom_scan
`default_nettype wire

// File: doc/rom_scan.md
Name: rom_scan

Overview:
- Upstream feeder for the bank-switch scheme detectors.
- After a cartridge image is loaded into cart BRAM, it walks the image byte by byte through a read port.
- It streams each (address, byte) pair with a strobe to the detector bank.
- It signals completion so the mapper-select logic can latch the detector results.

Parameters:
- READ_LATENCY, 1, cycles from mem_addr/mem_rd to valid mem_data (1..3).
- ADDR_W, 15, byte address width; maximum image size 2^ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request scan; rising edge sampled
- rom_size  in  16  image length in bytes, sampled on accepted start
- mem_grant  in  1  BRAM read port available this cycle
- mem_rd  out  1  read request
- mem_addr  out  ADDR_W  read address
- mem_data  in  8  read data, valid READ_LATENCY cycles after mem_rd
- det_clear  out  1  one-cycle pulse to clear detector history before the first byte
- scan_ena  out  1  byte strobe to detectors
- scan_addr  out  ADDR_W  address of the strobed byte
- scan_data  out  8  strobed byte
- busy  out  1  scan in progress
- done  out  1  scan complete (level)

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, start edge detector cleared, pipeline valid bits cleared.
- Start detection: start_q registers start. An accepted start is start & ~start_q, seen while in IDLE or DONE. Start edges in CLEAR, SCAN or DRAIN are ignored.
- Size rule: effective size N = min(rom_size, 2^ADDR_W).
- States and transitions:
  - IDLE: wait for an accepted start → CLEAR.
  - CLEAR:
    - det_clear=1 and busy=1 for exactly one cycle.
    - done drops to 0 in this cycle.
    - Issue counter resets to 0; latches N.
    - Next state is SCAN if N>0, else DONE (busy falls, done rises the following cycle, no scan_ena).
  - SCAN:
    - Each cycle with mem_grant=1: mem_rd=1, mem_addr=issue counter, counter increments.
    - With mem_grant=0: mem_rd=0, counter holds; in-flight reads still complete.
    - After issuing address N-1 → DRAIN.
  - DRAIN: no new reads; wait until the pipeline is empty → DONE.
  - DONE: busy=0, done=1; hold until the next accepted start.
- Return path:
  - A READ_LATENCY-deep shift register carries valid and address alongside each issued read.
  - When the valid bit emerges, register scan_ena=1, scan_addr=carried address, scan_data=mem_data (one register stage).
  - scan_ena is therefore READ_LATENCY+1 cycles after the corresponding mem_rd.
- Ordering guarantee: exactly N scan_ena pulses; addresses strictly ascending 0..N-1, no gaps, no duplicates, regardless of mem_grant pattern.
- Completion timing: done rises the cycle after the final scan_ena. busy is high from CLEAR through the cycle of the final scan_ena.
- Wrap-around: the issue counter is ADDR_W+1 bits wide, so N=2^ADDR_W terminates correctly without wrapping to 0.
- mem_addr in non-read cycles: holds its last value; not meaningful when mem_rd=0.
- Reset mid-scan: in-flight data is discarded, no further scan_ena, outputs go to their reset values immediately.

Decomposition:
- Shared package (cart_pkg):
  - ADDR_W default
  - MAX_ROM_BYTES
  - scan state enum (IDLE, CLEAR, SCAN, DRAIN, DONE)
- Sub-module rd_pipe: parameterised READ_LATENCY valid/address delay line with async reset. Reusable by other BRAM readers.

Test Plan:
- N=4, READ_LATENCY=1, mem_grant=1, BRAM holds 8D E0 1F 00:
  - det_clear pulses once.
  - scan_ena on 4 consecutive cycles, addr 0..3, data 8D,E0,1F,00.
  - Downstream E0 detector flags a match.
  - done=1 one cycle after the last strobe.
- N=16, mem_grant toggling 1,0,0,1,…:
  - 16 strobes, addresses 0..15 ascending, none duplicated.
  - busy high throughout; done only after the last strobe.
- rom_size=0 → CLEAR then DONE: zero scan_ena, busy high exactly 1 cycle. rom_size=40000 with ADDR_W=15 → exactly 32768 strobes; last addr 7FFF.
- READ_LATENCY=3, N=5: each scan_ena 4 cycles after its mem_rd; DRAIN lasts until the 5th strobe.
- Start held high, or re-pulsed during SCAN → ignored, no restart. New edge in DONE → done drops in the CLEAR cycle and a full rescan occurs.
- reset asserted mid-SCAN at addr 7 → all outputs 0 that cycle, no strobes after release. A following start rescans from addr 0.
